result_save_send: RTL and testbench

RESULT_SAVE_SEND -- requirements
Module: result_save_send

---
 rtl/result_save_send_pkg.sv | 25 ++
 rtl/result_save_send_if.sv | 26 ++
 rtl/rss_sync_fifo.sv | 49 ++++
 rtl/result_save_send.sv | 157 +++++++++++++++
 tb/tb_result_save_send.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/result_save_send_pkg.sv
// rtl/result_save_send_pkg.sv - shared constants, read FSM encoding and header builder for result_save_send
package result_save_send_pkg;

    // Header word layout: {40'd0, 8'd0, pu_id[7:0], total[7:0]}
    localparam int HDR_TOTAL_LSB = 0;
    localparam int HDR_PU_LSB    = 8;

    // Longest payload a single packet may carry; total (payload + header) must fit in 8 bits
    localparam logic [7:0] MAX_PAYLOAD = 8'd254;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } rd_state_t;

    function automatic logic [63:0] make_header(input logic [7:0] pu_id, input logic [7:0] payload_len);
        logic [63:0] h;
        h = '0;
        h[HDR_PU_LSB +: 8]    = pu_id;
        h[HDR_TOTAL_LSB +: 8] = payload_len + 8'd1;
        return h;
    endfunction

endpackage

// File: rtl/result_save_send_if.sv
// rtl/result_save_send_if.sv - engine-side result stream and collector-side packet stream
// Engine side : in_vld, in_data[63:0], in_last -> ; <- in_rdy
// Collector   : start -> ; <- vld, empty, eop, data[63:0]
// Status      : <- ovf_err
interface result_save_send_if;
    logic        in_vld;
    logic [63:0] in_data;
    logic        in_last;
    logic        in_rdy;
    logic        start;
    logic        vld;
    logic        empty;
    logic        eop;
    logic [63:0] data;
    logic        ovf_err;

    modport slave (
        input  in_vld, in_data, in_last, start,
        output in_rdy, vld, empty, eop, data, ovf_err
    );

    modport master (
        output in_vld, in_data, in_last, start,
        input  in_rdy, vld, empty, eop, data, ovf_err
    );
endinterface

// File: rtl/rss_sync_fifo.sv
// rtl/rss_sync_fifo.sv - synchronous first-word-fall-through FIFO with wrap-bit pointers
// Ports: sys_clk, sys_rst_n (async, active-low); wr_en/wr_data write port;
//        rd_en pops, rd_data always shows the head entry; full, empty, count (occupancy).
module rss_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Requests against a full/empty FIFO are ignored so the pointers can never cross
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/result_save_send.sv
// rtl/result_save_send.sv - buffers per-read results and sends them as header-prefixed packets on request
// Ports: sys_clk, sys_rst_n (async, active-low);
//        bus.in_vld/in_data/in_last/in_rdy : result words from the CIGAR engine
//        bus.start/vld/eop/data/empty      : packet stream toward the collector
//        bus.ovf_err                        : sticky drop/truncation flag
module result_save_send
    import result_save_send_pkg::*;
#(
    parameter logic [7:0] PU_ID      = 8'd0,
    parameter int         DATA_DEPTH = 512,
    parameter int         LEN_DEPTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    result_save_send_if.slave     bus
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    // in_rdy only while a whole worst-case packet (254 words + slack) still fits
    localparam logic [DAW+1:0] DATA_RDY_LIMIT = (DAW+2)'(DATA_DEPTH - 255);
    localparam logic [LAW+1:0] LEN_RDY_LIMIT  = (LAW+2)'(LEN_DEPTH);

    // Write side
    logic        in_rdy_q;
    logic        ovf_q;
    logic [7:0]  pay_cnt;
    logic        acc;
    logic        store;

    // Data buffer and length queue
    logic        d_wr, d_rd, d_full, d_empty;
    logic [63:0] d_dout;
    logic [DAW:0] d_cnt;
    logic        l_wr, l_rd, l_full, l_empty;
    logic [7:0]  l_din, l_dout;
    logic [LAW:0] l_cnt;
    logic [DAW+1:0] d_cnt_nxt;
    logic [LAW+1:0] l_cnt_nxt;

    // Read side
    rd_state_t   state;
    logic [7:0]  rem;
    logic        vld_q;
    logic        eop_q;
    logic [63:0] data_q;

    assign acc   = bus.in_vld && in_rdy_q;
    assign store = acc && (pay_cnt < MAX_PAYLOAD) && !d_full;
    assign d_wr  = store;
    assign l_wr  = acc && bus.in_last && !l_full;
    // When the payload limit was hit the last word itself was dropped, so the length saturates
    assign l_din = (pay_cnt < MAX_PAYLOAD) ? pay_cnt + 8'd1 : MAX_PAYLOAD;

    // HDR pops word 0; each BODY cycle with words remaining pops the next one
    assign d_rd = !d_empty && ((state == ST_HDR) || ((state == ST_BODY) && (rem != 8'd0)));
    assign l_rd = (state == ST_BODY) && (rem == 8'd0);

    // Ready is judged on the occupancy after this cycle's traffic, so the cycle of
    // latency in the registered in_rdy can never overrun either FIFO
    assign d_cnt_nxt = {1'b0, d_cnt} + (DAW+2)'(d_wr) - (DAW+2)'(d_rd);
    assign l_cnt_nxt = {1'b0, l_cnt} + (LAW+2)'(l_wr) - (LAW+2)'(l_rd);

    rss_sync_fifo #(.WIDTH(64), .DEPTH(DATA_DEPTH)) u_data_buf (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (d_wr),
        .wr_data   (bus.in_data),
        .rd_en     (d_rd),
        .rd_data   (d_dout),
        .full      (d_full),
        .empty     (d_empty),
        .count     (d_cnt)
    );

    rss_sync_fifo #(.WIDTH(8), .DEPTH(LEN_DEPTH)) u_len_queue (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (l_wr),
        .wr_data   (l_din),
        .rd_en     (l_rd),
        .rd_data   (l_dout),
        .full      (l_full),
        .empty     (l_empty),
        .count     (l_cnt)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_rdy_q <= 1'b0;
            ovf_q    <= 1'b0;
            pay_cnt  <= 8'd0;
        end else begin
            in_rdy_q <= (d_cnt_nxt <= DATA_RDY_LIMIT) && (l_cnt_nxt < LEN_RDY_LIMIT);
            if ((bus.in_vld && !in_rdy_q) || (acc && !store)) ovf_q <= 1'b1;
            if (acc) begin
                if (bus.in_last)  pay_cnt <= 8'd0;
                else if (store)   pay_cnt <= pay_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            rem    <= 8'd0;
            vld_q  <= 1'b0;
            eop_q  <= 1'b0;
            data_q <= 64'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    eop_q <= 1'b0;
                    if (bus.start && !l_empty) begin
                        state  <= ST_HDR;
                        vld_q  <= 1'b1;
                        data_q <= make_header(PU_ID, l_dout);
                        rem    <= l_dout;
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
                ST_HDR: begin
                    state  <= ST_BODY;
                    vld_q  <= 1'b1;
                    data_q <= d_dout;
                    eop_q  <= (rem == 8'd1);
                    rem    <= rem - 8'd1;
                end
                ST_BODY: begin
                    if (rem == 8'd0) begin
                        state <= ST_IDLE;
                        vld_q <= 1'b0;
                        eop_q <= 1'b0;
                    end else begin
                        vld_q  <= 1'b1;
                        data_q <= d_dout;
                        eop_q  <= (rem == 8'd1);
                        rem    <= rem - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    vld_q <= 1'b0;
                    eop_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.ovf_err = ovf_q;
    assign bus.vld     = vld_q;
    assign bus.eop     = eop_q;
    assign bus.data    = data_q;
    assign bus.empty   = l_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_result_save_send.sv
// tb/tb_result_save_send.sv - directed self-checking bench for result_save_send
module tb_result_save_send;
    localparam logic [7:0] TB_PU = 8'hA5;

    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   failures;

    result_save_send_if bus ();

    result_save_send #(.PU_ID(TB_PU), .DATA_DEPTH(512), .LEN_DEPTH(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_words(input int n, input logic [63:0] base, input bit close);
        for (int i = 0; i < n; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = base + 64'(i);
            bus.in_last = close && (i == n - 1);
            tick();
        end
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic recv(input int n, input logic [63:0] base, input logic [7:0] total, input bit hold_start);
        bus.start = 1'b1;
        tick();
        if (!hold_start) bus.start = 1'b0;
        chk("hdr_vld",   64'(bus.vld),   64'd1);
        chk("hdr_data",  bus.data,       {48'd0, TB_PU, total});
        chk("hdr_eop",   64'(bus.eop),   64'd0);
        chk("hdr_empty", 64'(bus.empty), 64'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("body_vld",   64'(bus.vld),   64'd1);
            chk("body_data",  bus.data,       base + 64'(i));
            chk("body_eop",   64'(bus.eop),   64'(i == n - 1));
            chk("body_empty", 64'(bus.empty), 64'd0);
        end
        bus.start = 1'b0;
        tick();
        chk("post_vld",  64'(bus.vld), 64'd0);
        chk("post_eop",  64'(bus.eop), 64'd0);
        chk("data_hold", bus.data,     base + 64'(n - 1));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        sys_rst_n   = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = 64'd0;
        bus.in_last = 1'b0;
        bus.start   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_rdy", 64'(bus.in_rdy),  64'd0);
        chk("rst_vld",    64'(bus.vld),     64'd0);
        chk("rst_eop",    64'(bus.eop),     64'd0);
        chk("rst_data",   bus.data,         64'd0);
        chk("rst_empty",  64'(bus.empty),   64'd1);
        chk("rst_ovf",    64'(bus.ovf_err), 64'd0);
        sys_rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 64'(bus.in_rdy), 64'd1);

        // 3-word packet, start held high through the packet to show it is ignored while busy
        drive_words(2, 64'h100, 1'b0);
        chk("empty_partial", 64'(bus.empty), 64'd1);
        drive_words(1, 64'h102, 1'b1);
        chk("empty_closed", 64'(bus.empty), 64'd0);
        recv(3, 64'h100, 8'd4, 1'b1);
        chk("empty_after_3w", 64'(bus.empty), 64'd1);

        // Three 1-word packets queued, drained in order
        drive_words(1, 64'h200, 1'b1);
        drive_words(1, 64'h300, 1'b1);
        drive_words(1, 64'h400, 1'b1);
        recv(1, 64'h200, 8'd2, 1'b1);
        tick();
        chk("no_spurious_vld", 64'(bus.vld),   64'd0);
        chk("queue_not_empty", 64'(bus.empty), 64'd0);
        recv(1, 64'h300, 8'd2, 1'b0);
        recv(1, 64'h400, 8'd2, 1'b0);
        chk("empty_after_3p", 64'(bus.empty),   64'd1);
        chk("ovf_clean",      64'(bus.ovf_err), 64'd0);

        // Start with nothing queued
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("nopkt_vld",   64'(bus.vld),   64'd0);
        chk("nopkt_empty", 64'(bus.empty), 64'd1);
        tick();
        chk("nopkt_vld2",  64'(bus.vld),   64'd0);

        // 300-word packet truncated to 254 payload words
        drive_words(300, 64'h3000, 1'b1);
        chk("trunc_ovf",   64'(bus.ovf_err), 64'd1);
        chk("trunc_empty", 64'(bus.empty),   64'd0);
        recv(254, 64'h3000, 8'd255, 1'b0);
        chk("trunc_done_empty", 64'(bus.empty), 64'd1);

        // Reset during BODY discards everything
        drive_words(5, 64'h500, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("mid_body_vld", 64'(bus.vld), 64'd1);
        sys_rst_n = 1'b0;
        tick();
        chk("rst_mid_vld",   64'(bus.vld),     64'd0);
        chk("rst_mid_eop",   64'(bus.eop),     64'd0);
        chk("rst_mid_empty", 64'(bus.empty),   64'd1);
        chk("rst_mid_ovf",   64'(bus.ovf_err), 64'd0);
        sys_rst_n = 1'b1;
        tick();
        drive_words(2, 64'h600, 1'b1);
        recv(2, 64'h600, 8'd3, 1'b0);
        chk("post_rst_empty", 64'(bus.empty), 64'd1);

        // Fill until in_rdy drops: packet A 200 words, then 60 words of B of which 58 fit
        drive_words(200, 64'h1000, 1'b1);
        chk("fill_rdy_a", 64'(bus.in_rdy),  64'd1);
        chk("fill_ovf_a", 64'(bus.ovf_err), 64'd0);
        drive_words(60, 64'h2000, 1'b1);
        chk("fill_rdy_low", 64'(bus.in_rdy),  64'd0);
        chk("fill_ovf",     64'(bus.ovf_err), 64'd1);
        // Send A while the two dropped B words are re-presented and B closes
        fork
            recv(200, 64'h1000, 8'd201, 1'b0);
            begin
                repeat (5) tick();
                chk("tail_rdy", 64'(bus.in_rdy), 64'd1);
                drive_words(2, 64'h2000 + 64'd58, 1'b1);
            end
        join
        chk("b_queued", 64'(bus.empty), 64'd0);
        recv(60, 64'h2000, 8'd61, 1'b0);
        chk("final_empty", 64'(bus.empty),   64'd1);
        chk("final_ovf",   64'(bus.ovf_err), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
